// File: rtl/frogger_pkg.sv
// Shared constants, types and helpers for the Frogger lane engine.
package frogger_pkg;

  localparam int GAME_WIDTH     = 20;
  localparam int ROAD_ROW0      = 8;
  localparam int RIVER_ROW0     = 1;
  localparam int NUM_LANES      = 8;
  localparam int LANES_PER_SIDE = 4;

  typedef logic [GAME_WIDTH-1:0] lane_t;

  typedef enum logic [3:0] {
    CELL_BG    = 4'd0,
    CELL_CAR   = 4'd1,
    CELL_WATER = 4'd2,
    CELL_LOG   = 4'd3,
    CELL_GOAL  = 4'd4
  } cell_code_t;

  // Rotation direction of a lane: even lanes move left, odd lanes move right.
  localparam bit DIR_LEFT  = 1'b0;
  localparam bit DIR_RIGHT = 1'b1;

  // Power-up occupancy of each lane; bit c is column c.
  localparam lane_t INIT_PATTERN [NUM_LANES] = '{
    20'h0E070,
    20'h30C03,
    20'h01818,
    20'h60006,
    20'h0FF80,
    20'h7C1F0,
    20'h3E00F,
    20'hF00F0
  };

  // Ticks between rotations of each lane at the slow speed level.
  localparam int LANE_DIV [NUM_LANES] = '{2, 3, 4, 3, 3, 4, 2, 5};

  // Which lane, if any, a playfield row belongs to.
  typedef struct packed {
    logic       road;
    logic       river;
    logic [2:0] lane;
  } row_info_t;

  // Bit of a lane pattern at a column; columns off the field read as empty.
  function automatic logic cell_bit(input lane_t pat, input logic [5:0] col);
    logic b;
    b = 1'b0;
    for (int c = 0; c < GAME_WIDTH; c++) begin
      if (col == 6'(c)) b = pat[c];
    end
    return b;
  endfunction

endpackage

// File: rtl/lane_shifter.sv
// One scrolling lane: a tick-driven down-counter and the rotating pattern.
module lane_shifter
  import frogger_pkg::*;
#(
  parameter lane_t INIT = '0,
  parameter int    DIV  = 2,
  parameter bit    DIR  = DIR_LEFT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tick,
  input  logic  fast,
  output lane_t pattern,
  output logic  rotate
);

  localparam int         DIV_HALF    = ((DIV >> 1) > 0) ? (DIV >> 1) : 1;
  localparam logic [3:0] RELOAD_SLOW = 4'(DIV);
  localparam logic [3:0] RELOAD_FAST = 4'(DIV_HALF);
  localparam int         W           = $bits(lane_t);

  logic [3:0] count;

  assign rotate = tick && (count == 4'd1);

  // Count ticks down; on the last one reload at the current speed and rotate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= RELOAD_SLOW;
      pattern <= INIT;
    end else if (rotate) begin
      count <= fast ? RELOAD_FAST : RELOAD_SLOW;
      if (DIR == DIR_LEFT) pattern <= {pattern[0], pattern[W-1:1]};
      else                 pattern <= {pattern[W-2:0], pattern[W-1]};
    end else if (tick) begin
      count <= count - 4'd1;
    end
  end

endmodule

// File: rtl/obstacle_ctrl.sv
// Lane engine: scrolls road and river lanes, judges the frog cell and
// serves cell codes to the pixel path.
module obstacle_ctrl #(
  parameter int STEP_CYCLES   = 2_500_000,
  parameter int SPEEDUP_SCORE = 8,
  parameter int GAME_WIDTH    = 20,
  parameter int ROAD_ROW0     = 8,
  parameter int RIVER_ROW0    = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [5:0] i_Frogger_X,
  input  logic [5:0] i_Frogger_Y,
  input  logic [6:0] i_Score,
  input  logic [5:0] i_Col_Count_Div,
  input  logic [5:0] i_Row_Count_Div,
  output logic       o_Collided,
  output logic       o_On_Log,
  output logic       o_Carry_Left,
  output logic       o_Carry_Right,
  output logic [3:0] o_Cell_Code
);

  import frogger_pkg::*;

  localparam int            TW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [5:0]    ROAD_LO   = 6'(ROAD_ROW0);
  localparam logic [5:0]    RIVER_LO  = 6'(RIVER_ROW0);
  localparam logic [5:0]    SIDE_N    = 6'(LANES_PER_SIDE);
  localparam logic [5:0]    X_LIMIT   = 6'(GAME_WIDTH);
  localparam logic [5:0]    X_LAST    = 6'(GAME_WIDTH - 1);

  lane_t                lane_pat [NUM_LANES];
  logic [NUM_LANES-1:0] lane_rot;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic                 fast;

  row_info_t  frog;
  row_info_t  query;
  logic       frog_bit;
  logic       frog_x_ok;
  logic       query_bit;
  logic       collide_next;
  logic       on_log_next;
  logic       carry_left_next;
  logic       carry_right_next;
  cell_code_t cell_next;

  // Road rows map to lanes 0..3, river rows to lanes 4..7.
  function automatic row_info_t decode_row(input logic [5:0] row);
    row_info_t  r;
    logic [5:0] off;
    r   = '0;
    off = '0;
    if (row >= ROAD_LO && row < ROAD_LO + SIDE_N) begin
      off    = row - ROAD_LO;
      r.road = 1'b1;
      r.lane = {1'b0, off[1:0]};
    end else if (row >= RIVER_LO && row < RIVER_LO + SIDE_N) begin
      off     = row - RIVER_LO;
      r.river = 1'b1;
      r.lane  = {1'b1, off[1:0]};
    end
    return r;
  endfunction

  assign tick = (tick_cnt == TICK_LAST);
  assign fast = (i_Score >= 7'(SPEEDUP_SCORE));

  // Global tick divider.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_shifter #(
      .INIT (INIT_PATTERN[i]),
      .DIV  (LANE_DIV[i]),
      .DIR  (((i % 2) == 1) ? DIR_RIGHT : DIR_LEFT)
    ) u_lane (
      .clk     (i_Clk),
      .rst_n   (i_Rst_L),
      .tick    (tick),
      .fast    (fast),
      .pattern (lane_pat[i]),
      .rotate  (lane_rot[i])
    );
  end

  // Judge the frog cell against the pre-rotation patterns, including carry off the edge.
  always_comb begin
    frog             = decode_row(i_Frogger_Y);
    frog_bit         = cell_bit(lane_pat[frog.lane], i_Frogger_X);
    frog_x_ok        = (i_Frogger_X < X_LIMIT);
    collide_next     = 1'b0;
    on_log_next      = 1'b0;
    carry_left_next  = 1'b0;
    carry_right_next = 1'b0;
    if (frog.road) begin
      collide_next = !frog_x_ok || frog_bit;
    end else if (frog.river) begin
      if (!frog_x_ok || !frog_bit) begin
        collide_next = 1'b1;
      end else begin
        on_log_next = 1'b1;
        if (lane_rot[frog.lane]) begin
          if (!frog.lane[0]) begin
            if (i_Frogger_X == 6'd0) collide_next    = 1'b1;
            else                     carry_left_next = 1'b1;
          end else begin
            if (i_Frogger_X == X_LAST) collide_next     = 1'b1;
            else                       carry_right_next = 1'b1;
          end
        end
      end
    end
  end

  // Cell code for the display query cell.
  always_comb begin
    query     = decode_row(i_Row_Count_Div);
    query_bit = cell_bit(lane_pat[query.lane], i_Col_Count_Div);
    cell_next = CELL_BG;
    if (i_Row_Count_Div == 6'd0) begin
      cell_next = CELL_GOAL;
    end else if (i_Col_Count_Div < X_LIMIT) begin
      if (query.road)       cell_next = query_bit ? CELL_CAR : CELL_BG;
      else if (query.river) cell_next = query_bit ? CELL_LOG : CELL_WATER;
    end
  end

  // Output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Collided    <= 1'b0;
      o_On_Log      <= 1'b0;
      o_Carry_Left  <= 1'b0;
      o_Carry_Right <= 1'b0;
      o_Cell_Code   <= 4'd0;
    end else begin
      o_Collided    <= collide_next;
      o_On_Log      <= on_log_next;
      o_Carry_Left  <= carry_left_next;
      o_Carry_Right <= carry_right_next;
      o_Cell_Code   <= cell_next;
    end
  end

endmodule

// File: tb/tb_obstacle_ctrl.sv
// Randomized self-checking bench for obstacle_ctrl against a time-based lane model.
module tb_obstacle_ctrl;

  import frogger_pkg::*;

  localparam int STEP  = 4;
  localparam int SPEED = 8;
  localparam int W     = 20;
  localparam int DIVS [8] = '{2, 3, 4, 3, 3, 4, 2, 5};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] frogX = '0;
  logic [5:0] frogY = '0;
  logic [6:0] score = '0;
  logic [5:0] qCol = '0;
  logic [5:0] qRow = '0;
  logic       collided;
  logic       onLog;
  logic       carryL;
  logic       carryR;
  logic [3:0] cellCode;

  int checks = 0;
  int errors = 0;

  // Model: edges since reset release, rotations done per lane, tick of next rotation.
  int cyc;
  int offset [8];
  int nextRot [8];
  int expCol, expOn, expCl, expCr, expCell;

  obstacle_ctrl #(
    .STEP_CYCLES   (STEP),
    .SPEEDUP_SCORE (SPEED),
    .GAME_WIDTH    (W),
    .ROAD_ROW0     (8),
    .RIVER_ROW0    (1)
  ) dut (
    .i_Clk           (clk),
    .i_Rst_L         (rst_n),
    .i_Frogger_X     (frogX),
    .i_Frogger_Y     (frogY),
    .i_Score         (score),
    .i_Col_Count_Div (qCol),
    .i_Row_Count_Div (qRow),
    .o_Collided      (collided),
    .o_On_Log        (onLog),
    .o_Carry_Left    (carryL),
    .o_Carry_Right   (carryR),
    .o_Cell_Code     (cellCode)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // After k rotations a left lane shows init[(c+k)%W], a right lane init[(c-k)%W].
  function automatic int patBit(input int lane, input int col);
    logic [19:0] pat;
    int k, idx;
    pat = INIT_PATTERN[lane];
    k   = offset[lane] % W;
    if (lane % 2 == 0) idx = (col + k) % W;
    else               idx = (col + W - k) % W;
    return int'(pat[idx]);
  endfunction

  function automatic int periodFor(input int lane, input int s);
    int p;
    p = (s < SPEED) ? DIVS[lane] : (DIVS[lane] / 2);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic int rowLane(input int row);
    if (row >= 8 && row <= 11) return row - 8;
    if (row >= 1 && row <= 4)  return row - 1 + 4;
    return -1;
  endfunction

  function automatic bit rotatesNow(input int lane);
    int e;
    e = cyc + 1;
    return (e % STEP == 0) && (e / STEP == nextRot[lane]);
  endfunction

  task automatic modelReset();
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      offset[i]  = 0;
      nextRot[i] = DIVS[i];
    end
  endtask

  task automatic modelAdvance();
    int e, t;
    e = cyc + 1;
    if (e % STEP == 0) begin
      t = e / STEP;
      for (int i = 0; i < 8; i++) begin
        if (t == nextRot[i]) begin
          offset[i]++;
          nextRot[i] = t + periodFor(i, int'(score));
        end
      end
    end
    cyc = e;
  endtask

  task automatic computeExpected();
    int x, y, lane, b, qc, qr, ql;
    x = int'(frogX); y = int'(frogY);
    qc = int'(qCol); qr = int'(qRow);
    expCol = 0; expOn = 0; expCl = 0; expCr = 0; expCell = 0;
    lane = rowLane(y);
    if (lane >= 0) begin
      b = (x < W) ? patBit(lane, x) : 0;
      if (lane < 4) begin
        expCol = (x >= W || b == 1) ? 1 : 0;
      end else if (x >= W || b == 0) begin
        expCol = 1;
      end else begin
        expOn = 1;
        if (rotatesNow(lane)) begin
          if (lane % 2 == 0) begin
            if (x == 0) expCol = 1; else expCl = 1;
          end else begin
            if (x == W - 1) expCol = 1; else expCr = 1;
          end
        end
      end
    end
    ql = rowLane(qr);
    if (qr == 0) expCell = 4;
    else if (ql >= 0 && qc < W) begin
      b = patBit(ql, qc);
      if (ql < 4) expCell = b;
      else        expCell = (b == 1) ? 3 : 2;
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input int s, input int qc, input int qr);
    frogX = 6'(x); frogY = 6'(y); score = 7'(s);
    qCol = 6'(qc); qRow = 6'(qr);
    computeExpected();
    @(posedge clk);
    #1;
    modelAdvance();
    checkOutput("collided", int'(collided), expCol);
    checkOutput("onLog", int'(onLog), expOn);
    checkOutput("carryLeft", int'(carryL), expCl);
    checkOutput("carryRight", int'(carryR), expCr);
    checkOutput("cellCode", int'(cellCode), expCell);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rstCollided", int'(collided), 0);
    checkOutput("rstOnLog", int'(onLog), 0);
    checkOutput("rstCarryLeft", int'(carryL), 0);
    checkOutput("rstCarryRight", int'(carryR), 0);
    checkOutput("rstCellCode", int'(cellCode), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  // Frog column biased toward log cells and field edges of its lane.
  function automatic int pickX(input int lane);
    int sel, n;
    int logs [$];
    sel = int'($urandom_range(0, 9));
    if (lane < 0 || sel < 3) return int'($urandom_range(0, 25));
    for (int c = 0; c < W; c++) if (patBit(lane, c) == 1) logs.push_back(c);
    if (sel < 6) begin
      if (patBit(lane, 0) == 1 && lane % 2 == 0) return 0;
      if (patBit(lane, W - 1) == 1 && lane % 2 == 1) return W - 1;
    end
    n = logs.size();
    if (n == 0) return 0;
    return logs[$urandom_range(0, n - 1)];
  endfunction

  initial begin
    int y, s;
    modelReset();
    #2;
    doReset();

    // Lane-0 scroll timing seen through the display query, frog off the lanes.
    for (int i = 0; i < 40; i++) applyStimulus(int'($urandom_range(0, 25)), 13, 0, i % W, 8);
    // Frog parked on road lane 0 at column 5 while it scrolls.
    for (int i = 0; i < 40; i++) applyStimulus(5, 8, 0, 3, 0);
    // River lane 4 at columns 7 and 0, lane 5 water, off-field column.
    for (int i = 0; i < 40; i++) applyStimulus(7, 1, 3, 22, 2);
    for (int i = 0; i < 40; i++) applyStimulus(0, 1, 3, i % W, 2);
    for (int i = 0; i < 20; i++) applyStimulus(25, 3, 3, i % W, 3);
    // Fast speed level, then slow again, watching lane 2.
    for (int i = 0; i < 60; i++) applyStimulus(3, 10, 8, i % W, 10);
    for (int i = 0; i < 60; i++) applyStimulus(3, 10, 7, i % W, 10);

    // Randomized play with occasional speed changes and mid-run resets.
    s = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) s = (($urandom_range(0, 1)) == 1) ? int'($urandom_range(8, 127)) : int'($urandom_range(0, 7));
      if (i % 700 == 699) doReset();
      y = int'($urandom_range(0, 13));
      applyStimulus(pickX(rowLane(y)), y, s, int'($urandom_range(0, 23)), int'($urandom_range(0, 13)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
